// File: rtl/traffic_light_checker_pkg.sv
// rtl/traffic_light_checker_pkg.sv - phase/state encodings, lamp patterns and error codes
package traffic_light_checker_pkg;

    typedef enum logic [1:0] {
        PH_NSG = 2'd0,
        PH_NSY = 2'd1,
        PH_EWG = 2'd2,
        PH_EWY = 2'd3
    } phase_e;

    // Low two bits of the tracking states equal the phase they track.
    typedef enum logic [2:0] {
        S_NSG  = 3'd0,
        S_NSY  = 3'd1,
        S_EWG  = 3'd2,
        S_EWY  = 3'd3,
        S_SYNC = 3'd4
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_ORDER   = 3'd2;
    localparam logic [2:0] ERR_SHORT   = 3'd3;
    localparam logic [2:0] ERR_LONG    = 3'd4;

    // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
    localparam logic [5:0] LAMP_NSG = 6'b100_001;
    localparam logic [5:0] LAMP_NSY = 6'b010_001;
    localparam logic [5:0] LAMP_EWG = 6'b001_100;
    localparam logic [5:0] LAMP_EWY = 6'b001_010;

    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(p + 2'd1);
    endfunction

endpackage

// File: rtl/traffic_light_checker_if.sv
// rtl/traffic_light_checker_if.sv - observed lamp bus plus 1 Hz tick
interface traffic_light_checker_if;
    logic tick;
    logic ns_g, ns_y, ns_r;
    logic ew_g, ew_y, ew_r;

    modport master (output tick, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r);
    modport slave  (input  tick, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r);
endinterface

// File: rtl/traffic_light_checker_lamp_decoder.sv
// rtl/traffic_light_checker_lamp_decoder.sv - six lamps to {legal, pattern}
module traffic_light_checker_lamp_decoder
    import traffic_light_checker_pkg::*;
(
    input  logic [5:0] lamps_i,
    output logic       legal_o,
    output phase_e     pattern_o
);

    always_comb begin
        legal_o   = 1'b1;
        pattern_o = PH_NSG;
        case (lamps_i)
            LAMP_NSG: pattern_o = PH_NSG;
            LAMP_NSY: pattern_o = PH_NSY;
            LAMP_EWG: pattern_o = PH_EWG;
            LAMP_EWY: pattern_o = PH_EWY;
            default:  legal_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_checker.sv
// rtl/traffic_light_checker.sv - on-line order/dwell/safety monitor for the lamp interface
module traffic_light_checker
    import traffic_light_checker_pkg::*;
#(
    parameter int DUR_G = 5,
    parameter int DUR_Y = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    traffic_light_checker_if.slave lamp_if,
    output logic [1:0]            phase,
    output logic                  in_sync,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      cycles
);

    localparam int DUR_MAX = (DUR_G > DUR_Y) ? DUR_G : DUR_Y;
    localparam int DW      = $clog2(DUR_MAX + 1) + 1;

    logic       legal;
    phase_e     pat;
    logic [5:0] lamps;

    assign lamps = {lamp_if.ns_g, lamp_if.ns_y, lamp_if.ns_r,
                    lamp_if.ew_g, lamp_if.ew_y, lamp_if.ew_r};

    traffic_light_checker_lamp_decoder u_dec (
        .lamps_i   (lamps),
        .legal_o   (legal),
        .pattern_o (pat)
    );

    state_e            state_q, state_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic              err_q, err_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              prev_nsg_q, prev_nsg_d;

    phase_e        cur_ph;
    logic [DW-1:0] dur_cur;
    logic [DW-1:0] dwell_new;
    logic [2:0]    viol;

    assign cur_ph    = phase_e'(state_q[1:0]);
    assign dur_cur   = (cur_ph == PH_NSG || cur_ph == PH_EWG) ? DW'(DUR_G) : DW'(DUR_Y);
    // A tick coinciding with a phase change is credited to the new phase.
    assign dwell_new = lamp_if.tick ? DW'(1) : DW'(0);
    assign prev_nsg_d = legal && (pat == PH_NSG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_NSG;
            dwell_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_pulse_q <= 1'b0;
            cycles_q    <= '0;
            prev_nsg_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_pulse_q <= err_pulse_d;
            cycles_q    <= cycles_d;
            prev_nsg_q  <= prev_nsg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_pulse_d = 1'b0;
        cycles_d    = cycles_q;
        viol        = ERR_NONE;
        if (state_q == S_SYNC) begin
            // Only a fresh edge into NSG relocks; a lingering NSG does not.
            if (legal && pat == PH_NSG && !prev_nsg_q) begin
                state_d = S_NSG;
                dwell_d = dwell_new;
            end
        end else if (!legal) begin
            viol = ERR_ILLEGAL;
        end else if (pat == cur_ph) begin
            if (lamp_if.tick) begin
                if (dwell_q >= dur_cur) viol = ERR_LONG;
                else                    dwell_d = dwell_q + DW'(1);
            end
        end else if (pat == next_phase(cur_ph)) begin
            if (dwell_q != dur_cur) begin
                viol = ERR_SHORT;
            end else begin
                state_d = state_e'({1'b0, pat});
                dwell_d = dwell_new;
                if (cur_ph == PH_EWY && cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
            end
        end else begin
            viol = ERR_ORDER;
        end
        if (viol != ERR_NONE) begin
            state_d     = S_SYNC;
            err_d       = 1'b1;
            err_pulse_d = 1'b1;
            if (!err_q) err_code_d = viol;
        end
    end

    always_comb begin
        phase     = state_q[1:0];
        in_sync   = (state_q != S_SYNC);
        err       = err_q;
        err_code  = err_code_q;
        err_pulse = err_pulse_q;
        cycles    = cycles_q;
    end

endmodule

// File: tb/tb_traffic_light_checker.sv
// tb/tb_traffic_light_checker.sv - directed self-checking bench for traffic_light_checker
module tb_traffic_light_checker;

    localparam logic [5:0] L_NSG  = 6'b100_001;
    localparam logic [5:0] L_NSY  = 6'b010_001;
    localparam logic [5:0] L_EWG  = 6'b001_100;
    localparam logic [5:0] L_EWY  = 6'b001_010;
    localparam logic [5:0] L_CONF = 6'b100_100;
    localparam logic [5:0] L_DARK = 6'b000_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] phase;
    logic       in_sync, err, err_pulse;
    logic [2:0] err_code;
    logic [7:0] cycles;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    logic seen_err = 1'b0;

    traffic_light_checker_if lamp_if ();

    traffic_light_checker #(.DUR_G(5), .DUR_Y(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .lamp_if   (lamp_if.slave),
        .phase     (phase),
        .in_sync   (in_sync),
        .err       (err),
        .err_code  (err_code),
        .err_pulse (err_pulse),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic set_lamps(input logic [5:0] v);
        {lamp_if.ns_g, lamp_if.ns_y, lamp_if.ns_r, lamp_if.ew_g, lamp_if.ew_y, lamp_if.ew_r} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
        if (err) seen_err = 1'b1;
    endtask

    task automatic run_phase(input logic [5:0] v, input int n);
        set_lamps(v);
        lamp_if.tick = 1'b0;
        step();
        for (int i = 0; i < n; i++) begin
            lamp_if.tick = 1'b1;
            step();
            lamp_if.tick = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_lamps(L_NSG);
        lamp_if.tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        seen_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (phase !== 2'd0)    begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        total++; if (in_sync !== 1'b1)  begin bad++; $display("FAIL reset_in_sync got=%0b exp=1", in_sync); end
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
        total++; if (err_code !== 3'd0) begin bad++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); end
        total++; if (cycles !== 8'd0)   begin bad++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
    endtask

    task automatic test_normal();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            run_phase(L_NSG, 5); run_phase(L_NSY, 2); run_phase(L_EWG, 5); run_phase(L_EWY, 2);
        end
        run_phase(L_NSG, 5); run_phase(L_NSY, 2); run_phase(L_EWG, 1);
        total++; if (seen_err !== 1'b0) begin bad++; $display("FAIL normal_err_seen got=%0b exp=0", seen_err); end
        total++; if (cycles !== 8'd2)   begin bad++; $display("FAIL normal_cycles got=%0d exp=2", cycles); end
        total++; if (phase !== 2'd2)    begin bad++; $display("FAIL normal_phase got=%0d exp=2", phase); end
        total++; if (in_sync !== 1'b1)  begin bad++; $display("FAIL normal_in_sync got=%0b exp=1", in_sync); end
    endtask

    task automatic test_illegal();
        do_reset();
        run_phase(L_NSG, 2);
        set_lamps(L_CONF);
        step();
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%0b exp=1", err_pulse); end
        total++; if (err !== 1'b1)       begin bad++; $display("FAIL illegal_err got=%0b exp=1", err); end
        total++; if (err_code !== 3'd1)  begin bad++; $display("FAIL illegal_code got=%0d exp=1", err_code); end
        total++; if (in_sync !== 1'b0)   begin bad++; $display("FAIL illegal_in_sync got=%0b exp=0", in_sync); end
        set_lamps(L_NSG);
        step();
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL illegal_pulse_clear got=%0b exp=0", err_pulse); end
        total++; if (in_sync !== 1'b1)   begin bad++; $display("FAIL illegal_resync got=%0b exp=1", in_sync); end
        total++; if (pulses != 1)        begin bad++; $display("FAIL illegal_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_short_long();
        do_reset();
        run_phase(L_NSG, 3);
        run_phase(L_NSY, 0);
        total++; if (err_code !== 3'd3) begin bad++; $display("FAIL short_code got=%0d exp=3", err_code); end
        do_reset();
        run_phase(L_NSG, 5);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL long_5th_err got=%0b exp=0", err); end
        lamp_if.tick = 1'b1;
        step();
        lamp_if.tick = 1'b0;
        total++; if (err_code !== 3'd4)  begin bad++; $display("FAIL long_code got=%0d exp=4", err_code); end
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL long_pulse got=%0b exp=1", err_pulse); end
        step(); step();
        total++; if (in_sync !== 1'b0) begin bad++; $display("FAIL long_no_fresh_edge got=%0b exp=0", in_sync); end
    endtask

    task automatic test_order();
        do_reset();
        run_phase(L_NSG, 5);
        run_phase(L_EWG, 0);
        total++; if (err_code !== 3'd2) begin bad++; $display("FAIL order_code got=%0d exp=2", err_code); end
        run_phase(L_EWY, 0);
        total++; if (in_sync !== 1'b0) begin bad++; $display("FAIL order_still_unsync got=%0b exp=0", in_sync); end
        run_phase(L_NSG, 0);
        total++; if (in_sync !== 1'b1 || phase !== 2'd0) begin
            bad++; $display("FAIL order_resync got=%0b/%0d exp=1/0", in_sync, phase); end
        lamp_if.tick = 1'b0;
        for (int i = 0; i < 5; i++) begin lamp_if.tick = 1'b1; step(); lamp_if.tick = 1'b0; step(); end
        run_phase(L_NSY, 2); run_phase(L_EWG, 5); run_phase(L_EWY, 2); run_phase(L_NSG, 0);
        total++; if (cycles !== 8'd1)   begin bad++; $display("FAIL order_clean_cycles got=%0d exp=1", cycles); end
        total++; if (err_code !== 3'd2) begin bad++; $display("FAIL order_code_held got=%0d exp=2", err_code); end
        total++; if (pulses != 1)       begin bad++; $display("FAIL order_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_two_errors();
        do_reset();
        set_lamps(L_DARK);
        step();
        run_phase(L_NSG, 2);
        run_phase(L_NSY, 0);
        total++; if (pulses != 2)       begin bad++; $display("FAIL two_pulse_count got=%0d exp=2", pulses); end
        total++; if (err_code !== 3'd1) begin bad++; $display("FAIL two_code_first got=%0d exp=1", err_code); end
        total++; if (in_sync !== 1'b0)  begin bad++; $display("FAIL two_in_sync got=%0b exp=0", in_sync); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        set_lamps(L_DARK);
        step();
        run_phase(L_NSG, 5); run_phase(L_NSY, 2); run_phase(L_EWG, 5); run_phase(L_EWY, 1);
        total++; if (phase !== 2'd3 || err !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre got=%0d/%0b exp=3/1", phase, err); end
        rst = 1'b1;
        #1;
        total++; if ({phase, in_sync, err, err_code, err_pulse, cycles} !== {2'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0}) begin
            bad++; $display("FAIL rstmid_async got=%0d/%0b/%0b/%0d/%0b/%0d exp=0/1/0/0/0/0",
                            phase, in_sync, err, err_code, err_pulse, cycles); end
        set_lamps(L_NSG);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        run_phase(L_NSG, 5);
        for (int c = 1; c <= 257; c++) begin
            run_phase(L_NSY, 2); run_phase(L_EWG, 5); run_phase(L_EWY, 2); run_phase(L_NSG, 5);
            if (c == 254) begin
                total++; if (cycles !== 8'hFE) begin bad++; $display("FAIL sat_254 got=%0d exp=254", cycles); end
            end
            if (c == 255) begin
                total++; if (cycles !== 8'hFF) begin bad++; $display("FAIL sat_255 got=%0d exp=255", cycles); end
            end
        end
        total++; if (cycles !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%0d exp=255", cycles); end
        total++; if (seen_err !== 1'b0) begin bad++; $display("FAIL sat_err_seen got=%0b exp=0", seen_err); end
    endtask

    initial begin
        lamp_if.tick = 1'b0;
        set_lamps(L_NSG);
        test_reset();
        test_normal();
        test_illegal();
        test_short_long();
        test_order();
        test_two_errors();
        test_rst_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
